// File: rtl/fx2_reg_cmd_engine.sv
// Register command engine: parses SYNC/mode/address/value frames from the FX2
// byte stream, issues one bus write and/or read, and streams the value back.
module fx2_reg_cmd_engine #(
  parameter int         ADDR_BYTES   = 2,
  parameter int         DATA_BYTES   = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hAA,
  parameter int         BYTE_TIMEOUT = 1023,
  parameter int         ACK_TIMEOUT  = 63
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*ADDR_BYTES-1:0] reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_wr,
  output logic                    reg_rd,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  input  logic                    reg_ack,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int IW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam int KW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MODE, S_ADDR, S_DATA, S_WRITE, S_READ, S_REPLY
  } state_t;

  state_t                  state, state_next;
  logic                    wr_flag;
  logic [3:0]              field_cnt;
  logic [IW-1:0]           idle_cnt;
  logic [KW-1:0]           ack_cnt;
  logic                    strobe_pend;
  logic [8*DATA_BYTES-1:0] reply_sr;
  logic                    err_next;
  logic                    in_xfer, out_xfer;
  logic                    in_frame, wait_ack;
  logic                    byte_to, ack_to;

  assign in_frame  = (state == S_MODE) || (state == S_ADDR) || (state == S_DATA);
  assign wait_ack  = (state == S_WRITE) || (state == S_READ);
  assign in_ready  = (state == S_IDLE) || in_frame;
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_REPLY);
  assign out_data  = (state == S_REPLY) ? reply_sr[7:0] : 8'h00;
  assign reg_wr    = (state == S_WRITE) && strobe_pend;
  assign reg_rd    = (state == S_READ) && strobe_pend;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Timeouts fire on the last idle clock so the error pulse follows immediately.
  assign byte_to = in_frame && !in_xfer && (idle_cnt == IW'(BYTE_TIMEOUT - 1));
  assign ack_to  = wait_ack && !reg_ack && (ack_cnt == KW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      S_IDLE:
        if (in_xfer && in_data == SYNC_BYTE) state_next = S_MODE;
      S_MODE:
        if (byte_to) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
        end else if (in_xfer) begin
          if (in_data[7:1] != 7'd0) begin
            state_next = S_IDLE;
            err_next   = 1'b1;
          end else begin
            state_next = S_ADDR;
          end
        end
      S_ADDR:
        if (byte_to) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
        end else if (in_xfer && field_cnt == 4'(ADDR_BYTES - 1)) begin
          state_next = S_DATA;
        end
      S_DATA:
        if (byte_to) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
        end else if (in_xfer && field_cnt == 4'(DATA_BYTES - 1)) begin
          state_next = wr_flag ? S_WRITE : S_READ;
        end
      S_WRITE:
        if (reg_ack) begin
          state_next = S_READ;
        end else if (ack_to) begin
          state_next = S_REPLY;
          err_next   = 1'b1;
        end
      S_READ:
        if (reg_ack) begin
          state_next = S_REPLY;
        end else if (ack_to) begin
          state_next = S_REPLY;
          err_next   = 1'b1;
        end
      S_REPLY:
        if (out_xfer && field_cnt == 4'(DATA_BYTES - 1)) state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  // Counters restart on every state change; the strobe flag marks the first
  // cycle of WRITE/READ so each strobe lasts exactly one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_flag     <= 1'b0;
      field_cnt   <= 4'd0;
      idle_cnt    <= '0;
      ack_cnt     <= '0;
      strobe_pend <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reply_sr    <= '0;
      frame_err   <= 1'b0;
    end else begin
      frame_err   <= err_next;
      strobe_pend <= (state_next != state) &&
                     (state_next == S_WRITE || state_next == S_READ);

      if (state_next != state)
        field_cnt <= 4'd0;
      else if (((state == S_ADDR || state == S_DATA) && in_xfer) ||
               (state == S_REPLY && out_xfer))
        field_cnt <= field_cnt + 4'd1;

      if (state_next != state || in_xfer) idle_cnt <= '0;
      else if (in_frame)                  idle_cnt <= idle_cnt + 1'b1;

      if (state_next != state) ack_cnt <= '0;
      else if (wait_ack)       ack_cnt <= ack_cnt + 1'b1;

      if (state == S_MODE && in_xfer) wr_flag <= in_data[0];

      if (state == S_ADDR && in_xfer)
        for (int i = 0; i < ADDR_BYTES; i++)
          if (field_cnt == 4'(i)) reg_addr[8*i +: 8] <= in_data;

      if (state == S_DATA && in_xfer)
        for (int i = 0; i < DATA_BYTES; i++)
          if (field_cnt == 4'(i)) reg_wdata[8*i +: 8] <= in_data;

      // A missing ack still yields a full-length reply, filled with ones.
      if (state == S_READ && reg_ack)
        reply_sr <= reg_rdata;
      else if (ack_to)
        reply_sr <= '1;
      else if (state == S_REPLY && out_xfer)
        reply_sr <= reply_sr >> 8;
    end
  end

endmodule

// File: tb/tb_fx2_reg_cmd_engine.sv
// Directed bench for fx2_reg_cmd_engine: default 2/4-byte instance plus a
// 1/6-byte instance, selected by 'sel'.
module tb_fx2_reg_cmd_engine;

  localparam int BT = 1023;
  localparam int AT = 63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, out_ready, sel, ack_same;
  logic [7:0]  in_data;
  logic [63:0] rdata;
  int          ack_dly;
  logic        reg_ack_d = 1'b0;
  logic        reg_ack;

  logic        a_in_ready, a_wr, a_rd, a_out_valid, a_err, a_busy;
  logic [15:0] a_addr;
  logic [31:0] a_wdata;
  logic [7:0]  a_out_data;
  logic        b_in_ready, b_wr, b_rd, b_out_valid, b_err, b_busy;
  logic [7:0]  b_addr;
  logic [47:0] b_wdata;
  logic [7:0]  b_out_data;

  logic        m_in_ready, m_wr, m_rd, m_out_valid, m_err, m_busy;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_out_data;

  int checks = 0;
  int errors = 0;

  fx2_reg_cmd_engine #(.ADDR_BYTES(2), .DATA_BYTES(4), .SYNC_BYTE(8'hAA),
                       .BYTE_TIMEOUT(BT), .ACK_TIMEOUT(AT)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid & ~sel),
    .in_ready(a_in_ready), .reg_addr(a_addr), .reg_wdata(a_wdata), .reg_wr(a_wr),
    .reg_rd(a_rd), .reg_rdata(rdata[31:0]), .reg_ack(reg_ack & ~sel),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready & ~sel),
    .frame_err(a_err), .busy(a_busy));

  fx2_reg_cmd_engine #(.ADDR_BYTES(1), .DATA_BYTES(6), .SYNC_BYTE(8'hAA),
                       .BYTE_TIMEOUT(BT), .ACK_TIMEOUT(AT)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid & sel),
    .in_ready(b_in_ready), .reg_addr(b_addr), .reg_wdata(b_wdata), .reg_wr(b_wr),
    .reg_rd(b_rd), .reg_rdata(rdata[47:0]), .reg_ack(reg_ack & sel),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready & sel),
    .frame_err(b_err), .busy(b_busy));

  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_wr        = sel ? b_wr        : a_wr;
  assign m_rd        = sel ? b_rd        : a_rd;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_data  = sel ? b_out_data  : a_out_data;
  assign m_err       = sel ? b_err       : a_err;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_addr      = sel ? {24'd0, b_addr}  : {16'd0, a_addr};
  assign m_wdata     = sel ? {16'd0, b_wdata} : {32'd0, a_wdata};
  assign reg_ack     = reg_ack_d | (ack_same & (m_wr | m_rd));

  // Bus responder and event recorder, sampled mid-cycle.
  int          cyc = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0, overlap_cnt = 0, in_cnt = 0;
  int          wr_cyc = 0, rd_cyc = 0, err_cyc = 0, last_in_cyc = 0, ack_pend = 0;
  logic [31:0] wr_addr = 0, rd_addr = 0;
  logic [63:0] wr_data = 0;
  logic [7:0]  reply_q[$];
  int          reply_cyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ack_pend > 1) begin
      ack_pend <= ack_pend - 1; reg_ack_d <= 1'b0;
    end else if (ack_pend == 1) begin
      ack_pend <= 0; reg_ack_d <= 1'b1;
    end else begin
      reg_ack_d <= 1'b0;
    end
    if ((m_wr || m_rd) && ack_dly > 0) ack_pend <= ack_dly;
    if (m_wr) begin wr_cnt <= wr_cnt + 1; wr_cyc <= cyc; wr_addr <= m_addr; wr_data <= m_wdata; end
    if (m_rd) begin rd_cnt <= rd_cnt + 1; rd_cyc <= cyc; rd_addr <= m_addr; end
    if (m_err) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
    if (m_err && (m_wr || m_rd)) overlap_cnt <= overlap_cnt + 1;
    if (in_valid && m_in_ready && reset_n) begin in_cnt <= in_cnt + 1; last_in_cyc <= cyc; end
    if (m_out_valid && out_ready && reset_n) begin
      reply_q.push_back(m_out_data);
      reply_cyc.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (m_in_ready) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL send_byte: in_ready stuck at %b, required 1", m_in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] mode, input logic [31:0] addr,
                            input logic [63:0] wdata, input int nab, input int ndb);
    send_byte(8'hAA);
    send_byte(mode);
    for (int i = 0; i < nab; i++) send_byte(addr[8*i +: 8]);
    for (int i = 0; i < ndb; i++) send_byte(wdata[8*i +: 8]);
  endtask

  task automatic wait_reply(input int base, input int n);
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (reply_q.size() - base >= n && !m_busy) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL wait_reply: got %0d bytes busy=%b, required %0d bytes and idle",
               reply_q.size() - base, m_busy, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_in_ready, m_wr, m_rd, m_out_valid, m_err, m_busy} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: {in_ready,wr,rd,out_valid,err,busy}=%b required 100000",
               {m_in_ready, m_wr, m_rd, m_out_valid, m_err, m_busy});
    end
    checks++;
    if (m_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_addr: %h required 0", m_addr); end
    checks++;
    if (m_wdata !== 64'd0) begin errors++; $display("[TB] FAIL reset_wdata: %h required 0", m_wdata); end
    checks++;
    if (m_out_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_data: %h required 0", m_out_data); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_garbage_read();
    int rb = reply_q.size();
    int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
    logic [31:0] exp = 32'h00000003;
    rdata = 64'h3; ack_dly = 2; ack_same = 1'b0;
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    @(posedge clk); #1;
    checks++;
    if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL garbage_err: %0d pulses required 0", err_cnt - e0); end
    checks++;
    if (m_busy !== 1'b0) begin errors++; $display("[TB] FAIL garbage_busy: %b required 0", m_busy); end
    send_frame(8'h00, 32'h0001, 64'h0, 2, 4);
    wait_reply(rb, 4);
    checks++;
    if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0) begin
      errors++; $display("[TB] FAIL read_strobes: rd=%0d wr=%0d required rd=1 wr=0", rd_cnt - r0, wr_cnt - w0);
    end
    checks++;
    if (rd_addr !== 32'h0001) begin errors++; $display("[TB] FAIL read_addr: %h required 0001", rd_addr); end
    checks++;
    if (rd_cyc !== last_in_cyc + 1) begin
      errors++; $display("[TB] FAIL read_latency: rd at %0d required %0d", rd_cyc, last_in_cyc + 1);
    end
    checks++;
    if (reply_q.size() - rb !== 4) begin errors++; $display("[TB] FAIL read_len: %0d required 4", reply_q.size() - rb); end
    for (int i = 0; i < 4 && rb + i < reply_q.size(); i++) begin
      checks++;
      if (reply_q[rb+i] !== exp[8*i +: 8]) begin
        errors++; $display("[TB] FAIL read_reply[%0d]: %h required %h", i, reply_q[rb+i], exp[8*i +: 8]);
      end
    end
    checks++;
    if (reply_q.size() - rb >= 4 && reply_cyc[rb+3] - reply_cyc[rb] !== 3) begin
      errors++; $display("[TB] FAIL read_bubbles: span %0d required 3", reply_cyc[rb+3] - reply_cyc[rb]);
    end
  endtask

  task automatic test_write_readback();
    int rb = reply_q.size();
    int w0 = wr_cnt, r0 = rd_cnt;
    logic [31:0] exp = 32'h0000000F;
    rdata = 64'hF; ack_dly = 0; ack_same = 1'b1;
    send_frame(8'h01, 32'h0004, 64'h0000000F, 2, 4);
    wait_reply(rb, 4);
    checks++;
    if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin
      errors++; $display("[TB] FAIL write_strobes: wr=%0d rd=%0d required 1 and 1", wr_cnt - w0, rd_cnt - r0);
    end
    checks++;
    if (wr_cyc !== last_in_cyc + 1) begin
      errors++; $display("[TB] FAIL write_latency: wr at %0d required %0d", wr_cyc, last_in_cyc + 1);
    end
    checks++;
    if (wr_addr !== 32'h0004 || wr_data !== 64'h0000000F) begin
      errors++; $display("[TB] FAIL write_fields: addr=%h wdata=%h required 0004 0000000f", wr_addr, wr_data);
    end
    checks++;
    if (rd_cyc !== wr_cyc + 1) begin
      errors++; $display("[TB] FAIL readback_latency: rd at %0d required %0d", rd_cyc, wr_cyc + 1);
    end
    for (int i = 0; i < 4 && rb + i < reply_q.size(); i++) begin
      checks++;
      if (reply_q[rb+i] !== exp[8*i +: 8]) begin
        errors++; $display("[TB] FAIL write_reply[%0d]: %h required %h", i, reply_q[rb+i], exp[8*i +: 8]);
      end
    end
    ack_same = 1'b0;
  endtask

  task automatic test_bad_mode();
    int rb, w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
    logic [31:0] exp = 32'hA1B2C3D4;
    ack_dly = 2;
    send_byte(8'hAA); send_byte(8'h02);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL mode_err_pulse: %0d cycles required 1", err_cnt - e0); end
    checks++;
    if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0 || m_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL mode_abort: wr=%0d rd=%0d busy=%b required 0 0 0", wr_cnt - w0, rd_cnt - r0, m_busy);
    end
    rb = reply_q.size();
    rdata = 64'hA1B2C3D4;
    send_frame(8'h00, 32'h0000AA34, 64'hAAAAAAAA, 2, 4);
    wait_reply(rb, 4);
    checks++;
    if (rd_addr !== 32'h0000AA34 || err_cnt - e0 !== 1) begin
      errors++; $display("[TB] FAIL sync_as_data: addr=%h errs=%0d required aa34 1", rd_addr, err_cnt - e0);
    end
    for (int i = 0; i < 4 && rb + i < reply_q.size(); i++) begin
      checks++;
      if (reply_q[rb+i] !== exp[8*i +: 8]) begin
        errors++; $display("[TB] FAIL mode_next_reply[%0d]: %h required %h", i, reply_q[rb+i], exp[8*i +: 8]);
      end
    end
  endtask

  task automatic test_byte_timeout();
    int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    for (int i = 0; i < BT + 50; i++) begin
      @(posedge clk); #1;
      if (err_cnt != e0) break;
    end
    @(posedge clk); #1;
    checks++;
    if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL byte_to_err: %0d pulses required 1", err_cnt - e0); end
    checks++;
    if (err_cyc - last_in_cyc !== BT + 1) begin
      errors++; $display("[TB] FAIL byte_to_time: %0d clocks required %0d", err_cyc - last_in_cyc, BT + 1);
    end
    checks++;
    if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0 || m_busy !== 1'b0 || m_in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL byte_to_abort: wr=%0d rd=%0d busy=%b in_ready=%b required 0 0 0 1",
                         wr_cnt - w0, rd_cnt - r0, m_busy, m_in_ready);
    end
  endtask

  task automatic test_ack_timeout();
    int rb = reply_q.size();
    int r0 = rd_cnt, e0 = err_cnt;
    logic [31:0] exp = 32'hFFFFFFFF;
    ack_dly = 0; ack_same = 1'b0; rdata = 64'h12345678;
    send_frame(8'h00, 32'h0042, 64'h0, 2, 4);
    wait_reply(rb, 4);
    checks++;
    if (rd_cnt - r0 !== 1 || err_cnt - e0 !== 1) begin
      errors++; $display("[TB] FAIL ack_to_counts: rd=%0d err=%0d required 1 1", rd_cnt - r0, err_cnt - e0);
    end
    checks++;
    if (err_cyc - rd_cyc !== AT) begin
      errors++; $display("[TB] FAIL ack_to_time: %0d clocks required %0d", err_cyc - rd_cyc, AT);
    end
    for (int i = 0; i < 4 && rb + i < reply_q.size(); i++) begin
      checks++;
      if (reply_q[rb+i] !== exp[8*i +: 8]) begin
        errors++; $display("[TB] FAIL ack_to_reply[%0d]: %h required %h", i, reply_q[rb+i], exp[8*i +: 8]);
      end
    end
    checks++;
    if (overlap_cnt !== 0) begin errors++; $display("[TB] FAIL err_strobe_overlap: %0d required 0", overlap_cnt); end
  endtask

  task automatic test_backpressure_reset();
    int rb = reply_q.size();
    bit done = 1'b0;
    logic [31:0] exp = 32'h44332211;
    ack_dly = 2; rdata = 64'h44332211;
    send_frame(8'h00, 32'h0010, 64'h0, 2, 4);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      if (reply_q.size() - rb >= 4 && !m_busy) begin done = 1'b1; break; end
    end
    out_ready = 1'b1;
    checks++;
    if (!done || reply_q.size() - rb !== 4) begin
      errors++; $display("[TB] FAIL bp_len: %0d bytes required 4", reply_q.size() - rb);
    end
    for (int i = 0; i < 4 && rb + i < reply_q.size(); i++) begin
      checks++;
      if (reply_q[rb+i] !== exp[8*i +: 8]) begin
        errors++; $display("[TB] FAIL bp_reply[%0d]: %h required %h", i, reply_q[rb+i], exp[8*i +: 8]);
      end
    end

    rb = reply_q.size();
    rdata = 64'h0D0C0B0A;
    send_frame(8'h00, 32'h0011, 64'h0, 2, 4);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_out_valid) break;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (m_out_valid !== 1'b1 || m_out_data !== 8'h0B) begin
      errors++; $display("[TB] FAIL bp_hold: valid=%b data=%h required 1 0b", m_out_valid, m_out_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset: valid=%b in_ready=%b busy=%b required 0 1 0",
                         m_out_valid, m_in_ready, m_busy);
    end
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (reply_q.size() - rb !== 1 || m_out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_residual: %0d bytes valid=%b required 1 0", reply_q.size() - rb, m_out_valid);
    end
    checks++;
    if (reply_q.size() > rb && reply_q[rb] !== 8'h0A) begin
      errors++; $display("[TB] FAIL reset_first_byte: %h required 0a", reply_q[rb]);
    end

    rb = reply_q.size();
    exp = 32'h88776655;
    rdata = 64'h88776655;
    send_frame(8'h00, 32'h0012, 64'h0, 2, 4);
    wait_reply(rb, 4);
    for (int i = 0; i < 4 && rb + i < reply_q.size(); i++) begin
      checks++;
      if (reply_q[rb+i] !== exp[8*i +: 8]) begin
        errors++; $display("[TB] FAIL post_reset_reply[%0d]: %h required %h", i, reply_q[rb+i], exp[8*i +: 8]);
      end
    end
  endtask

  task automatic test_wide();
    int rb, r0, w0, i0;
    logic [47:0] exp = 48'h665544332211;
    sel = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (m_in_ready !== 1'b1 || m_busy !== 1'b0 || m_out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL wide_reset: in_ready=%b busy=%b valid=%b required 1 0 0",
                         m_in_ready, m_busy, m_out_valid);
    end
    rb = reply_q.size(); r0 = rd_cnt; w0 = wr_cnt; i0 = in_cnt;
    ack_dly = 2; rdata = 64'h0000665544332211;
    send_frame(8'h00, 32'h5A, 64'h060504030201, 1, 6);
    wait_reply(rb, 6);
    checks++;
    if (in_cnt - i0 !== 9) begin errors++; $display("[TB] FAIL wide_frame_len: %0d bytes required 9", in_cnt - i0); end
    checks++;
    if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0 || rd_addr !== 32'h5A) begin
      errors++; $display("[TB] FAIL wide_read: rd=%0d wr=%0d addr=%h required 1 0 5a", rd_cnt - r0, wr_cnt - w0, rd_addr);
    end
    checks++;
    if (rd_cyc !== last_in_cyc + 1) begin
      errors++; $display("[TB] FAIL wide_latency: rd at %0d required %0d", rd_cyc, last_in_cyc + 1);
    end
    checks++;
    if (reply_q.size() - rb !== 6) begin errors++; $display("[TB] FAIL wide_len: %0d required 6", reply_q.size() - rb); end
    for (int i = 0; i < 6 && rb + i < reply_q.size(); i++) begin
      checks++;
      if (reply_q[rb+i] !== exp[8*i +: 8]) begin
        errors++; $display("[TB] FAIL wide_reply[%0d]: %h required %h", i, reply_q[rb+i], exp[8*i +: 8]);
      end
    end
    checks++;
    if (reply_q.size() - rb >= 6 && reply_cyc[rb+5] - reply_cyc[rb] !== 5) begin
      errors++; $display("[TB] FAIL wide_bubbles: span %0d required 5", reply_cyc[rb+5] - reply_cyc[rb]);
    end
  endtask

  initial begin
    sel = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    rdata = 64'd0; ack_same = 1'b0; ack_dly = 0; reset_n = 1'b0;
    $display("[TB] starting");
    test_reset();
    test_garbage_read();
    test_write_readback();
    test_bad_mode();
    test_byte_timeout();
    test_ack_timeout();
    test_backpressure_reset();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx2_reg_cmd_engine.md
Name: fx2_reg_cmd_engine

Overview:
Parametrised command engine between the FX2 command byte stream and the timetagger register bus. It parses framed register transactions of the form SYNC, mode, address, value. It issues one register write and/or read, then streams the register value back as a reply frame. Compared with the fixed 2-byte-address / 4-byte-value decoder, it adds configurable address and data widths, garbage resynchronisation, inter-byte timeout, bus-ack timeout and error reporting.

Parameters:
ADDR_BYTES, 2, address field length in bytes (1..4)
DATA_BYTES, 4, value field and reply length in bytes (1..8)
SYNC_BYTE, 8'hAA, frame start marker
BYTE_TIMEOUT, 1023, max idle clocks between bytes inside a frame
ACK_TIMEOUT, 63, max clocks waiting for reg_ack

Ports:
clk  in  1  system clock (fx2_clk domain)
reset_n  in  1  asynchronous active-low reset
in_data  in  8  command byte
in_valid  in  1  in_data valid
in_ready  out  1  engine accepts byte (transfer = in_valid & in_ready)
reg_addr  out  8*ADDR_BYTES  register address
reg_wdata  out  8*DATA_BYTES  write value
reg_wr  out  1  one-cycle write strobe
reg_rd  out  1  one-cycle read strobe
reg_rdata  in  8*DATA_BYTES  read value, valid with reg_ack
reg_ack  in  1  bus acknowledge for current strobe
out_data  out  8  reply byte
out_valid  out  1  reply byte valid
out_ready  in  1  downstream accepts (transfer = out_valid & out_ready)
frame_err  out  1  one-cycle pulse on any protocol error
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync deassert): state IDLE. in_ready=1. reg_wr=reg_rd=0. reg_addr=0, reg_wdata=0. out_valid=0, out_data=0. frame_err=0, busy=0. All counters clear. Reset mid-frame or mid-reply aborts with no residual output.
- States: IDLE, MODE, ADDR, DATA, WRITE, READ, REPLY.
- IDLE: in_ready=1. A byte equal to SYNC_BYTE -> MODE. Any other byte is silently discarded (no frame_err); the engine stays in IDLE.
- MODE: bit0 = write flag; bits[7:1] must be 0. A nonzero value in bits[7:1] pulses frame_err and returns to IDLE. Otherwise the engine latches the write flag and goes to ADDR.
- ADDR: accepts ADDR_BYTES bytes, LSB first, into reg_addr, then goes to DATA.
- DATA: accepts DATA_BYTES bytes, LSB first, into reg_wdata. The data bytes are always present, and ignored for reads.
- Field counters reset on every state entry.
- After the last DATA byte transfers at cycle N: write -> reg_wr=1 at N+1 (WRITE); read -> reg_rd=1 at N+1 (READ).
- in_ready=0 in WRITE, READ and REPLY.
- WRITE: reg_wr is high for exactly one cycle. On reg_ack the engine goes to READ; reg_rd pulses the cycle after ack (read-back).
- READ: reg_rd is high for exactly one cycle. On reg_ack it latches reg_rdata into the reply shift register and goes to REPLY.
- Ack in the same cycle as the strobe is legal.
- Ack timeout: ACK_TIMEOUT clocks without reg_ack pulse frame_err. The reply register is then loaded with all-ones and the engine proceeds to REPLY, so the host always receives DATA_BYTES bytes.
- REPLY: emits DATA_BYTES bytes, LSB first. out_data and out_valid are stable until the transfer. The next byte is presented the cycle after the transfer, so there are no bubbles when out_ready=1. The final transfer returns to IDLE with in_ready=1 in the next cycle.
- Byte timeout: the idle counter runs in MODE, ADDR and DATA and is cleared by every accepted byte. When it reaches BYTE_TIMEOUT, frame_err pulses, the frame is discarded and the engine returns to IDLE with no bus strobe.
- No timeout applies in REPLY; backpressure is unbounded.
- A SYNC_BYTE value inside MODE/ADDR/DATA is treated as data, not as resync.
- frame_err and the bus strobes are never high in the same cycle.
- Fields are zero-extended; no wrap. The address is passed through unmodified.

Test Plan:
- Garbage FF,FF,FF then AA,00,01,00,00,00,00,00 with rdata=32'h00000003, ack 2 clocks after reg_rd -> FF bytes dropped with no frame_err; reg_rd once with addr 16'h0001, no reg_wr; reply 03,00,00,00.
- Write AA,01,04,00,0F,00,00,00 with ack same cycle, readback rdata 32'h0000000F -> reg_wr at N+1 with addr 0004 and wdata 0000000F; reg_rd the cycle after ack; reply 0F,00,00,00.
- Mode byte 02 -> frame_err one cycle; no strobe. The following valid frame completes normally.
- Frame stalls after the second address byte for BYTE_TIMEOUT clocks -> frame_err; no strobe; IDLE; busy=0.
- reg_ack never asserted on a read -> frame_err after ACK_TIMEOUT; reply FF,FF,FF,FF.
- out_ready toggled 1/0 during reply; reset_n pulsed during second reply byte -> bytes are never duplicated or skipped; after reset out_valid=0, in_ready=1, and a new frame succeeds.
- Repeat the read scenario with ADDR_BYTES=1 and DATA_BYTES=6 -> 9-byte frame; 6-byte reply, LSB first.
